// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state and the muxed request bundle.
package dmem_port_arbiter_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic {ARB, FORCE} dmem_arb_state_e;

    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             func3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage (priority) and a debug/loader
// port; a starvation counter forces one debug slot after STARVE_LIM consecutive denied cycles.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_rd,
    input  logic                  pipe_wr,
    input  logic [DM_ADDRESS-1:0] pipe_addr,
    input  logic [DATA_W-1:0]     pipe_wdata,
    input  logic [2:0]            pipe_func3,
    output logic                  pipe_stall,
    output logic [DATA_W-1:0]     pipe_rdata,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_func3,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    dmem_arb_state_e state_reg, state_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic [CNT_W-1:0] starve_inc;
    logic             dbg_rvalid_reg;
    logic [DATA_W-1:0] dbg_rdata_reg;

    logic      pipe_req;
    logic      grant_pipe;
    logic      grant_dbg;
    dmem_req_t req_pipe;
    dmem_req_t req_dbg;
    dmem_req_t req_sel;

    assign pipe_req   = pipe_rd | pipe_wr;
    assign starve_inc = starve_cnt_reg + CNT_W'(1);

    always_comb begin
        grant_pipe      = 1'b0;
        grant_dbg       = 1'b0;
        pipe_stall      = 1'b0;
        dbg_ready       = 1'b0;
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;

        case (state_reg)
            ARB: begin
                if (pipe_req) begin
                    grant_pipe = 1'b1;
                end else if (dbg_valid) begin
                    grant_dbg = 1'b1;
                    dbg_ready = 1'b1;
                end
                if (dbg_valid && pipe_req) begin
                    starve_cnt_next = starve_inc;
                    if (starve_inc == CNT_W'(STARVE_LIM)) begin
                        state_next = FORCE;
                    end
                end else begin
                    starve_cnt_next = '0;
                end
            end
            FORCE: begin
                // A dropped dbg_valid here is a protocol violation; the slot goes back to the pipe.
                if (dbg_valid) begin
                    grant_dbg  = 1'b1;
                    dbg_ready  = 1'b1;
                    pipe_stall = pipe_req;
                end else begin
                    grant_pipe = 1'b1;
                end
                starve_cnt_next = '0;
                state_next      = ARB;
            end
            default: begin
                state_next      = ARB;
                starve_cnt_next = '0;
            end
        endcase

        if (reset) begin
            grant_pipe = 1'b0;
            grant_dbg  = 1'b0;
            pipe_stall = 1'b0;
            dbg_ready  = 1'b0;
        end
    end

    always_comb begin
        req_pipe.rd    = pipe_rd;
        req_pipe.wr    = pipe_wr;
        req_pipe.addr  = pipe_addr;
        req_pipe.wdata = pipe_wdata;
        req_pipe.func3 = pipe_func3;

        req_dbg.rd     = ~dbg_we;
        req_dbg.wr     = dbg_we;
        req_dbg.addr   = dbg_addr;
        req_dbg.wdata  = dbg_wdata;
        req_dbg.func3  = dbg_func3;

        req_sel = grant_dbg ? req_dbg : req_pipe;
    end

    // Address/data follow the pipe when nobody is granted; only the strobes are gated.
    assign mem_rd     = req_sel.rd & (grant_pipe | grant_dbg);
    assign mem_wr     = req_sel.wr & (grant_pipe | grant_dbg);
    assign mem_addr   = req_sel.addr;
    assign mem_wdata  = req_sel.wdata;
    assign mem_func3  = req_sel.func3;
    assign pipe_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB;
            starve_cnt_reg <= '0;
            dbg_rvalid_reg <= 1'b0;
            dbg_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            dbg_rvalid_reg <= grant_dbg & ~dbg_we;
            if (grant_dbg && !dbg_we) begin
                dbg_rdata_reg <= mem_rdata;
            end
        end
    end

    assign dbg_rvalid = dbg_rvalid_reg;
    assign dbg_rdata  = dbg_rdata_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural data memory plus a scoreboard of expected debug read data.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_rd, pipe_wr;
    logic [8:0]  pipe_addr;
    logic [31:0] pipe_wdata;
    logic [2:0]  pipe_func3;
    logic        pipe_stall;
    logic [31:0] pipe_rdata;
    logic        dbg_valid, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [2:0]  dbg_func3;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem [0:127];
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_LIM(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_func3(pipe_func3),
        .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_func3(dbg_func3),
        .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    // Word-wide memory with combinational read and write at the clock edge.
    assign mem_rdata = tb_mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_addr[8:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        else begin
            n_pass++;
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Scoreboard: every debug read response is matched against the oldest expected value.
    always @(negedge clk) begin
        if (!reset && dbg_rvalid) begin
            if (exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
            else check("dbg_rdata", dbg_rdata, exp_q.pop_front());
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        pipe_rd = 0; pipe_wr = 0; pipe_addr = '0; pipe_wdata = '0; pipe_func3 = 3'b010;
        dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_func3 = 3'b010;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) tb_mem[i] = '0;
        idle_inputs();
        reset = 1;
        pipe_wr = 1; dbg_valid = 1; dbg_we = 1;

        // Reset gating with both requesters active
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mem_wr", 32'(mem_wr), 32'd0);
            check("rst_dbg_ready", 32'(dbg_ready), 32'd0);
            check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
            step();
        end
        reset = 0;
        idle_inputs();
        @(negedge clk);
        check("post_rst_state", 32'(dut.state_reg), 32'(ARB));
        check("post_rst_cnt", 32'(dut.starve_cnt_reg), 32'd0);
        check("post_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        step();

        // Debug write then read with the pipe idle
        dbg_valid = 1; dbg_we = 1; dbg_addr = 9'h010; dbg_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("dbgw_ready", 32'(dbg_ready), 32'd1);
        check("dbgw_mem_wr", 32'(mem_wr), 32'd1);
        check("dbgw_addr", 32'(mem_addr), 32'h010);
        step();
        dbg_we = 0;
        @(negedge clk);
        check("dbgr_ready", 32'(dbg_ready), 32'd1);
        check("dbgr_mem_rd", 32'(mem_rd), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        step();
        dbg_valid = 0;
        step();

        // Starvation pattern: pipe_rd and dbg read held high for two full periods
        pipe_rd = 1; pipe_addr = 9'h040;
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("starve_ready_c%0d", c), 32'(dbg_ready), 32'((c % 5) == 4));
            check($sformatf("starve_stall_c%0d", c), 32'(pipe_stall), 32'((c % 5) == 4));
            check($sformatf("starve_addr_c%0d", c), 32'(mem_addr), (c % 5) == 4 ? 32'h010 : 32'h040);
            if (dbg_ready) exp_q.push_back(32'hDEADBEEF);
            step();
        end

        // Dropping dbg_valid clears the counter; four more denials needed
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("drop_pre_ready", 32'(dbg_ready), 32'd0);
            step();
        end
        dbg_valid = 0;
        step();
        dbg_valid = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("drop_ready_c%0d", c), 32'(dbg_ready), 32'(c == 4));
            if (dbg_ready) exp_q.push_back(32'hDEADBEEF);
            step();
        end

        // Same-address conflict: forced dbg write first, stalled pipe write next cycle
        dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'h11111111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("conf_deny_c%0d", c), 32'(dbg_ready), 32'd0);
            step();
        end
        pipe_rd = 0; pipe_wr = 1; pipe_addr = 9'h020; pipe_wdata = 32'h22222222;
        @(negedge clk);
        check("conf_n_stall", 32'(pipe_stall), 32'd1);
        check("conf_n_wr", 32'(mem_wr), 32'd1);
        check("conf_n_wdata", mem_wdata, 32'h11111111);
        step();
        dbg_valid = 0;
        @(negedge clk);
        check("conf_n1_stall", 32'(pipe_stall), 32'd0);
        check("conf_n1_wr", 32'(mem_wr), 32'd1);
        check("conf_n1_wdata", mem_wdata, 32'h22222222);
        step();
        pipe_wr = 0;
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h020;
        @(negedge clk);
        check("conf_rd_ready", 32'(dbg_ready), 32'd1);
        exp_q.push_back(32'h22222222);
        step();
        dbg_valid = 0;
        step();

        // Reset during FORCE with a dbg write pending
        pipe_rd = 1; pipe_addr = 9'h040;
        dbg_valid = 1; dbg_we = 1; dbg_addr = 9'h030; dbg_wdata = 32'h33333333;
        for (int c = 0; c < 4; c++) step();
        @(negedge clk);
        check("pre_rst_force_state", 32'(dut.state_reg), 32'(FORCE));
        #1;
        reset = 1;
        #1;
        check("rstf_mem_wr", 32'(mem_wr), 32'd0);
        check("rstf_dbg_ready", 32'(dbg_ready), 32'd0);
        check("rstf_pipe_stall", 32'(pipe_stall), 32'd0);
        step();
        reset = 0;
        idle_inputs();
        @(negedge clk);
        check("rstf_state", 32'(dut.state_reg), 32'(ARB));
        check("rstf_rvalid", 32'(dbg_rvalid), 32'd0);
        step();
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h030;
        @(negedge clk);
        exp_q.push_back(32'h00000000);
        step();
        dbg_valid = 0;
        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
